// File: rtl/spi_slave_sync.sv
// SPI responder oversampled in the system clock domain: 8-bit full-duplex frames,
// MSB first, all four modes, with a tx holding register and an rx data register.
//
// state | meaning
// IDLE  | ss high, miso tri-stated, waiting for synced ss to fall
// LOAD  | one cycle: holding register (or 0x00) moves into the tx shifter
// SHIFT | frame in progress, sampling/shifting on synced sclk edges
module spi_slave_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             sclk,
  input  logic             ss,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ack,
  output logic             overrun,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_pipe, ss_pipe, mosi_pipe;
  logic sclk_d, ss_d;
  logic sclk_s, ss_s, mosi_s;
  logic ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic lead_edge, trail_edge, sample_edge, shift_edge;

  logic [1:0]       mode_q;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] rx_shift, tx_shift, holding;
  logic             do_load, do_sample, do_shift, byte_done;

  // ss synchronizer resets to the inactive (high) level so release does not look like a frame start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_pipe <= '0;
      ss_pipe   <= '1;
      mosi_pipe <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], sclk};
      ss_pipe   <= {ss_pipe[SYNC_STAGES-2:0], ss};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  assign sclk_s = sclk_pipe[SYNC_STAGES-1];
  assign ss_s   = ss_pipe[SYNC_STAGES-1];
  assign mosi_s = mosi_pipe[SYNC_STAGES-1];

  assign ss_fall   = ss_d & ~ss_s;
  assign ss_rise   = ~ss_d & ss_s;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;

  assign lead_edge   = mode_q[1] ? sclk_fall : sclk_rise;
  assign trail_edge  = mode_q[1] ? sclk_rise : sclk_fall;
  assign sample_edge = mode_q[0] ? trail_edge : lead_edge;
  assign shift_edge  = mode_q[0] ? lead_edge : trail_edge;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_sample = 1'b0;
    do_shift  = 1'b0;
    byte_done = 1'b0;
    case (state)
      IDLE:  if (ss_fall) state_nxt = LOAD;
      LOAD: begin
        do_load   = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        do_sample = sample_edge;
        byte_done = sample_edge && (bit_cnt == LAST_BIT);
        // bit_cnt==0 marks the edge that merely presents bit 7 (CPHA=1 first edge,
        // or CPHA=0 trailing edge of the previous byte), so no shift there
        do_shift  = shift_edge && (bit_cnt != '0);
        if (byte_done) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
    if (ss_rise) begin
      state_nxt = IDLE;
      do_load   = 1'b0;
      do_sample = 1'b0;
      do_shift  = 1'b0;
      byte_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q   <= 2'b00;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      holding  <= '0;
      tx_ready <= 1'b1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (state == IDLE && ss_fall) mode_q <= mode;

      if (ss_rise || byte_done) bit_cnt <= '0;
      else if (do_sample)       bit_cnt <= bit_cnt + CNT_W'(1);

      if (ss_rise)        rx_shift <= '0;
      else if (do_sample) rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};

      if (do_load)       tx_shift <= tx_ready ? '0 : holding;
      else if (do_shift) tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};

      // a load in the LOAD cycle is accepted for the byte after the one being transferred
      if (do_load) begin
        if (tx_load) begin
          holding  <= tx_data;
          tx_ready <= 1'b0;
        end else begin
          tx_ready <= 1'b1;
        end
      end else if (tx_load && tx_ready) begin
        holding  <= tx_data;
        tx_ready <= 1'b0;
      end

      if (byte_done) begin
        rx_data  <= {rx_shift[WIDTH-2:0], mosi_s};
        rx_valid <= 1'b1;
        if (rx_valid && !rx_ack) overrun <= 1'b1;
      end else if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

  assign busy    = (state != IDLE);
  assign miso_oe = (state != IDLE) && !ss_rise;
  assign miso    = miso_oe & tx_shift[WIDTH-1];

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: the bench plays the SPI initiator and
// checks serial and local-side results against hand-computed values.
module tb_spi_slave_sync;

  localparam int H = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       sclk = 1'b0;
  logic       ss = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int failures = 0;

  spi_slave_sync #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sclk(sclk), .ss(ss), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_tx(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
  endtask

  task automatic ack_rx();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    tick(1);
  endtask

  task automatic ss_low(input logic [1:0] m);
    sclk = m[1];
    tick(6);
    mode = m;
    ss = 1'b0;
    tick(8);
  endtask

  task automatic ss_high();
    ss = 1'b1;
    tick(6);
  endtask

  task automatic spi_bits(input logic [1:0] m, input logic [7:0] mo, input int n,
                          output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (!m[0]) begin
        mosi = mo[7-i];
        tick(H);
        mi = {mi[6:0], miso};
        sclk = ~m[1];
        tick(H);
        sclk = m[1];
      end else begin
        sclk = ~m[1];
        mosi = mo[7-i];
        tick(H);
        mi = {mi[6:0], miso};
        sclk = m[1];
        tick(H);
      end
    end
    tick(H);
  endtask

  task automatic test_reset();
    logic [7:0] mi;
    tick(5);
    reset = 1'b1;
    tick(2);
    checks++; if (miso !== 1'b0)     begin failures++; $display("FAIL rst_miso got=%b exp=0", miso); end
    checks++; if (miso_oe !== 1'b0)  begin failures++; $display("FAIL rst_miso_oe got=%b exp=0", miso_oe); end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL rst_tx_ready got=%b exp=1", tx_ready); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL rst_rx_data got=%h exp=00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rst_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (overrun !== 1'b0)  begin failures++; $display("FAIL rst_overrun got=%b exp=0", overrun); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    // abort a frame at bit 4 with a byte pending in the holding register
    load_tx(8'h77);
    ss_low(2'b00);
    load_tx(8'h66);
    spi_bits(2'b00, 8'hFF, 4, mi);
    checks++; if (busy !== 1'b1 || tx_ready !== 1'b0) begin failures++; $display("FAIL midframe_pre busy=%b tx_ready=%b exp busy=1 tx_ready=0", busy, tx_ready); end
    reset = 1'b0;
    tick(2);
    checks++; if ({miso, miso_oe, busy, rx_valid, overrun} !== 5'b0)
      begin failures++; $display("FAIL midrst_outs got=%b exp=00000", {miso, miso_oe, busy, rx_valid, overrun}); end
    checks++; if (tx_ready !== 1'b1 || rx_data !== 8'h00)
      begin failures++; $display("FAIL midrst_tx_rx tx_ready=%b rx_data=%h exp 1/00", tx_ready, rx_data); end
    ss = 1'b1;
    sclk = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(12);
    checks++; if (rx_valid !== 1'b0 || busy !== 1'b0)
      begin failures++; $display("FAIL postrst rx_valid=%b busy=%b exp 0/0", rx_valid, busy); end
  endtask

  task automatic test_mode0();
    logic [7:0] mi;
    load_tx(8'hA5);
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL m0_loaded tx_ready got=%b exp=0", tx_ready); end
    ss_low(2'b00);
    checks++; if (miso_oe !== 1'b1 || busy !== 1'b1)
      begin failures++; $display("FAIL m0_oe_busy oe=%b busy=%b exp 1/1", miso_oe, busy); end
    spi_bits(2'b00, 8'h3C, 8, mi);
    checks++; if (mi !== 8'hA5)      begin failures++; $display("FAIL m0_miso got=%h exp=a5", mi); end
    checks++; if (rx_data !== 8'h3C) begin failures++; $display("FAIL m0_rx_data got=%h exp=3c", rx_data); end
    checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL m0_rx_valid got=%b exp=1", rx_valid); end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL m0_tx_ready got=%b exp=1", tx_ready); end
    ss_high();
    checks++; if (miso_oe !== 1'b0 || busy !== 1'b0)
      begin failures++; $display("FAIL m0_release oe=%b busy=%b exp 0/0", miso_oe, busy); end
    ack_rx();
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL m0_ack rx_valid got=%b exp=0", rx_valid); end
  endtask

  task automatic test_modes();
    logic [7:0] mi;
    for (int m = 1; m < 4; m++) begin
      load_tx(8'h55);
      ss_low(m[1:0]);
      mode = 2'b00;  // must be ignored mid-frame
      spi_bits(m[1:0], 8'hAA, 8, mi);
      ss_high();
      checks++; if (mi !== 8'h55)      begin failures++; $display("FAIL mode%0d_miso got=%h exp=55", m, mi); end
      checks++; if (rx_data !== 8'hAA || rx_valid !== 1'b1)
        begin failures++; $display("FAIL mode%0d_rx got=%h/%b exp=aa/1", m, rx_data, rx_valid); end
      checks++; if (tx_ready !== 1'b1 || overrun !== 1'b0)
        begin failures++; $display("FAIL mode%0d_flags tx_ready=%b overrun=%b exp 1/0", m, tx_ready, overrun); end
      ack_rx();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] mi1, mi2;
    load_tx(8'h81);
    ss_low(2'b00);
    spi_bits(2'b00, 8'h01, 8, mi1);
    checks++; if (rx_data !== 8'h01 || overrun !== 1'b0 || miso_oe !== 1'b1)
      begin failures++; $display("FAIL b2b_first rx=%h ovr=%b oe=%b exp 01/0/1", rx_data, overrun, miso_oe); end
    spi_bits(2'b00, 8'h02, 8, mi2);
    ss_high();
    checks++; if (mi1 !== 8'h81) begin failures++; $display("FAIL b2b_miso1 got=%h exp=81", mi1); end
    checks++; if (mi2 !== 8'h00) begin failures++; $display("FAIL b2b_miso2 got=%h exp=00", mi2); end
    checks++; if (rx_data !== 8'h02 || rx_valid !== 1'b1 || overrun !== 1'b1)
      begin failures++; $display("FAIL b2b_overrun rx=%h valid=%b ovr=%b exp 02/1/1", rx_data, rx_valid, overrun); end
    ack_rx();
    checks++; if (rx_valid !== 1'b0 || overrun !== 1'b0)
      begin failures++; $display("FAIL b2b_ack valid=%b ovr=%b exp 0/0", rx_valid, overrun); end
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    ss_low(2'b00);
    spi_bits(2'b00, 8'hFF, 5, mi);
    ss_high();
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL abort_partial rx_valid got=%b exp=0", rx_valid); end
    ss_low(2'b00);
    spi_bits(2'b00, 8'hF0, 8, mi);
    ss_high();
    checks++; if (rx_data !== 8'hF0 || rx_valid !== 1'b1 || overrun !== 1'b0)
      begin failures++; $display("FAIL abort_full rx=%h valid=%b ovr=%b exp f0/1/0", rx_data, rx_valid, overrun); end
    ack_rx();
  endtask

  task automatic test_tx_empty();
    logic [7:0] mi;
    ss_low(2'b00);
    spi_bits(2'b00, 8'h5A, 8, mi);
    ss_high();
    checks++; if (mi !== 8'h00)      begin failures++; $display("FAIL empty_miso got=%h exp=00", mi); end
    checks++; if (rx_data !== 8'h5A) begin failures++; $display("FAIL empty_rx got=%h exp=5a", rx_data); end
    ack_rx();
    load_tx(8'h3C);
    load_tx(8'h99);
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL ignored_load tx_ready got=%b exp=0", tx_ready); end
    ss_low(2'b11);
    spi_bits(2'b11, 8'hC3, 8, mi);
    ss_high();
    checks++; if (mi !== 8'h3C)      begin failures++; $display("FAIL ignored_load_miso got=%h exp=3c", mi); end
    checks++; if (rx_data !== 8'hC3) begin failures++; $display("FAIL ignored_load_rx got=%h exp=c3", rx_data); end
    ack_rx();
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_abort();
    test_tx_empty();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
